alu_issue_stage: RTL



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_opsel.sv | 41 ++++
 rtl/alu_issue_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the resolved issue entry, and the
// issue-stage occupancy states.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef struct packed {
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic [3:0]      opcode;
    logic [RIDX-1:0] rd;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_opsel.sv
// Combinational operand resolution: writeback forwarding, S2 immediate select
// and ALU opcode formation, producing a fully resolved issue entry.
module alu_opsel
  import alu_pkg::*;
(
  input  logic [RIDX-1:0] in_rs1,
  input  logic [RIDX-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_is_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [RIDX-1:0] in_rd,
  input  logic            fwd_valid,
  input  logic [RIDX-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output issue_entry_t    entry
);

  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;
  logic            f7_used;

  // x0 is hardwired zero, so a writeback aimed at it must never be forwarded.
  assign rs1_op = (fwd_valid && (fwd_rd == in_rs1) && (in_rs1 != '0)) ? fwd_data : in_rs1_val;
  assign rs2_op = (fwd_valid && (fwd_rd == in_rs2) && (in_rs2 != '0)) ? fwd_data : in_rs2_val;

  // Bit 30 only selects SUB (R-type) or SRA/SRAI; for ADDI it is immediate data.
  assign f7_used = (!in_is_imm && ((in_funct3 == 3'b000) || (in_funct3 == 3'b101))) ||
                   ( in_is_imm &&  (in_funct3 == 3'b101));

  always_comb begin
    entry        = '0;
    entry.s1     = rs1_op;
    entry.s2     = in_is_imm ? in_imm : rs2_op;
    entry.opcode = {f7_used & in_funct7_5, in_funct3};
    entry.rd     = in_rd;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue register: resolves operands at capture and holds up to two entries
// (head + skid) so decode never sees a combinational path from out_ready.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RIDX-1:0] in_rs1,
  input  logic [RIDX-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_is_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [RIDX-1:0] in_rd,
  input  logic            fwd_valid,
  input  logic [RIDX-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_s1,
  output logic [XLEN-1:0] out_s2,
  output logic [3:0]      out_opcode,
  output logic [RIDX-1:0] out_rd
);

  // Handshake: a transfer happens on a side exactly when valid && ready are
  // both high at the rising edge; a producer holding valid keeps its payload
  // stable until that edge, and ready never depends combinationally on valid.

  issue_state_t state_q;
  issue_entry_t head_q;
  issue_entry_t skid_q;
  issue_entry_t new_entry;
  logic         acc;
  logic         deq;

  alu_opsel u_opsel (
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .in_imm      (in_imm),
    .in_is_imm   (in_is_imm),
    .in_funct3   (in_funct3),
    .in_funct7_5 (in_funct7_5),
    .in_rd       (in_rd),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .entry       (new_entry)
  );

  assign in_ready  = (state_q != ST_FULL) && rst_n;
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign out_s1     = head_q.s1;
  assign out_s2     = head_q.s2;
  assign out_opcode = head_q.opcode;
  assign out_rd     = head_q.rd;

  // Flush discards everything, including an accept in the same cycle; a
  // dequeue in that cycle has already been taken by the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            head_q  <= new_entry;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            head_q <= new_entry;
          end else if (acc) begin
            skid_q  <= new_entry;
            state_q <= ST_FULL;
          end else if (deq) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deq) begin
            head_q  <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule
